// File: rtl/cr_ahbl_req_sched.sv
// cr_ahbl_req_sched: arbitrates ibus/dbus requests onto one pipelined AHB-Lite master port
module cr_ahbl_req_sched #(
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_W = 3
) (
  input  logic        forever_cpuclk,
  input  logic        cpurst,
  input  logic        ibus_req,
  input  logic [31:0] ibus_addr,
  input  logic [1:0]  ibus_size,
  input  logic [3:0]  ibus_prot,
  input  logic        dbus_req,
  input  logic [31:0] dbus_addr,
  input  logic [1:0]  dbus_size,
  input  logic [3:0]  dbus_prot,
  input  logic        dbus_write,
  input  logic [31:0] dbus_wdata,
  input  logic        power_mask,
  input  logic        cpu_req_grnt,
  input  logic        cpu_trans_cmplt,
  input  logic        cpu_data_vld,
  input  logic        cpu_acc_err,
  input  logic [31:0] cpu_rdata,
  output logic        cpu_req,
  output logic [31:0] cpu_addr,
  output logic [1:0]  cpu_size,
  output logic [3:0]  cpu_prot,
  output logic        cpu_write,
  output logic [31:0] cpu_wdata,
  output logic        ibus_grnt,
  output logic        dbus_grnt,
  output logic        ibus_data_vld,
  output logic        dbus_data_vld,
  output logic        ibus_trans_cmplt,
  output logic        dbus_trans_cmplt,
  output logic        ibus_acc_err,
  output logic        dbus_acc_err,
  output logic [31:0] bus_rdata,
  output logic        ibus_not_granted,
  output logic        sched_idle
);
  typedef enum logic [1:0] {NONE, IBUS, DBUS} own_t;
  typedef enum logic {IDLE, LOCK} state_t;
  state_t state;
  own_t addr_owner, data_owner, owner;
  logic [CNT_W-1:0] cnt;
  logic starved;
  always_comb begin
    starved = cnt >= CNT_W'(STARVE_LIMIT);
    owner = state == LOCK ? addr_owner :
            power_mask ? NONE :
            (dbus_req && (!starved || !ibus_req)) ? DBUS :
            ibus_req ? IBUS : NONE;
  end
  assign cpu_req          = owner != NONE;
  assign cpu_addr         = owner == DBUS ? dbus_addr : owner == IBUS ? ibus_addr : '0;
  assign cpu_size         = owner == DBUS ? dbus_size : owner == IBUS ? ibus_size : '0;
  assign cpu_prot         = owner == DBUS ? dbus_prot : owner == IBUS ? ibus_prot : '0;
  assign cpu_write        = owner == DBUS && dbus_write;
  assign ibus_grnt        = cpu_req_grnt && owner == IBUS;
  assign dbus_grnt        = cpu_req_grnt && owner == DBUS;
  assign ibus_trans_cmplt = cpu_trans_cmplt && data_owner == IBUS;
  assign dbus_trans_cmplt = cpu_trans_cmplt && data_owner == DBUS;
  assign ibus_data_vld    = cpu_data_vld && data_owner == IBUS;
  assign dbus_data_vld    = cpu_data_vld && data_owner == DBUS;
  assign ibus_acc_err     = cpu_acc_err && ibus_trans_cmplt;
  assign dbus_acc_err     = cpu_acc_err && dbus_trans_cmplt;
  assign bus_rdata        = cpu_rdata;
  assign ibus_not_granted = ibus_req && !ibus_grnt;
  assign sched_idle       = state == IDLE && data_owner == NONE;
  always_ff @(posedge forever_cpuclk) begin
    if (cpurst) begin
      state      <= IDLE;
      addr_owner <= NONE;
      data_owner <= NONE;
      cnt        <= '0;
      cpu_wdata  <= '0;
    end else begin
      state <= state == IDLE ? ((cpu_req && !cpu_req_grnt) ? LOCK : IDLE) : (cpu_req_grnt ? IDLE : LOCK);
      if (state == IDLE) addr_owner <= owner;
      data_owner <= (cpu_req && cpu_req_grnt) ? owner : cpu_trans_cmplt ? NONE : data_owner;
      if (dbus_grnt && dbus_write) cpu_wdata <= dbus_wdata;
      cnt <= (ibus_grnt || !ibus_req) ? '0 : (dbus_grnt && !starved) ? cnt + 1'b1 : cnt;
    end
  end
endmodule

// File: tb/tb_cr_ahbl_req_sched.sv
// tb_cr_ahbl_req_sched: vector, directed and randomized checks against a transaction-level model
module tb_cr_ahbl_req_sched;
  localparam int LIM = 4;
  logic clk = 0, rst = 0;
  logic ireq = 0, dreq = 0, dwr = 0, pm = 0, grnt = 0, cmplt = 0, vld = 0, err = 0;
  logic [31:0] iaddr = 0, daddr = 0, dwd = 0, rdata = 0;
  logic [1:0] isize = 2'b10, dsize = 2'b01;
  logic [3:0] iprot = 4'h3, dprot = 4'h1;
  logic cpu_req, cpu_write, ibus_grnt, dbus_grnt, ivld, dvld, icmp, dcmp, ierr, derr, ing, idle;
  logic [31:0] cpu_addr, cpu_wdata, bus_rdata;
  logic [1:0] cpu_size;
  logic [3:0] cpu_prot;
  int checks = 0, failures = 0;
  int m_lock = 0, m_aown = 0, m_down = 0, m_cnt = 0;
  logic [31:0] m_wdata = 0;
  logic s_req, s_ig, s_dg, s_ivld, s_icmp, s_dcmp, s_ierr, s_idle, s_ing;
  logic [31:0] s_addr, s_wdata, s_rdata;

  always #5 clk = ~clk;

  cr_ahbl_req_sched #(.STARVE_LIMIT(LIM), .CNT_W(3)) dut (
    .forever_cpuclk(clk), .cpurst(rst),
    .ibus_req(ireq), .ibus_addr(iaddr), .ibus_size(isize), .ibus_prot(iprot),
    .dbus_req(dreq), .dbus_addr(daddr), .dbus_size(dsize), .dbus_prot(dprot),
    .dbus_write(dwr), .dbus_wdata(dwd), .power_mask(pm),
    .cpu_req_grnt(grnt), .cpu_trans_cmplt(cmplt), .cpu_data_vld(vld), .cpu_acc_err(err),
    .cpu_rdata(rdata), .cpu_req(cpu_req), .cpu_addr(cpu_addr), .cpu_size(cpu_size),
    .cpu_prot(cpu_prot), .cpu_write(cpu_write), .cpu_wdata(cpu_wdata),
    .ibus_grnt(ibus_grnt), .dbus_grnt(dbus_grnt), .ibus_data_vld(ivld), .dbus_data_vld(dvld),
    .ibus_trans_cmplt(icmp), .dbus_trans_cmplt(dcmp), .ibus_acc_err(ierr), .dbus_acc_err(derr),
    .bus_rdata(bus_rdata), .ibus_not_granted(ing), .sched_idle(idle)
  );

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s got=%h exp=%h t=%0t", n, a, e, $time);
    end
  endtask

  // called at a negedge with inputs already applied; returns at the following negedge
  task automatic step();
    int own;
    logic e_ig, e_dg;
    #2;
    own = m_lock ? m_aown : pm ? 0 : (dreq && (m_cnt < LIM || !ireq)) ? 2 : ireq ? 1 : 0;
    e_ig = grnt && own == 1;
    e_dg = grnt && own == 2;
    {s_req, s_ig, s_dg, s_ivld, s_icmp, s_dcmp, s_ierr, s_idle, s_ing} =
      {cpu_req, ibus_grnt, dbus_grnt, ivld, icmp, dcmp, ierr, idle, ing};
    {s_addr, s_wdata, s_rdata} = {cpu_addr, cpu_wdata, bus_rdata};
    chk("flags", {20'd0, cpu_req, cpu_write, ibus_grnt, dbus_grnt, ivld, dvld, icmp, dcmp, ierr, derr, ing, idle},
        {20'd0, own != 0, own == 2 && dwr, e_ig, e_dg, vld && m_down == 1, vld && m_down == 2,
         cmplt && m_down == 1, cmplt && m_down == 2, err && cmplt && m_down == 1, err && cmplt && m_down == 2,
         ireq && !e_ig, m_lock == 0 && m_down == 0});
    chk("cpu_addr", cpu_addr, own == 2 ? daddr : own == 1 ? iaddr : 32'd0);
    chk("size_prot", {26'd0, cpu_size, cpu_prot}, own == 2 ? {26'd0, dsize, dprot} : own == 1 ? {26'd0, isize, iprot} : 32'd0);
    chk("cpu_wdata", cpu_wdata, m_wdata);
    chk("bus_rdata", bus_rdata, rdata);
    if (rst) begin
      m_lock = 0; m_aown = 0; m_down = 0; m_cnt = 0; m_wdata = 0;
    end else begin
      if (grnt && own != 0) m_down = own;
      else if (cmplt) m_down = 0;
      if (e_dg && dwr) m_wdata = dwd;
      if (e_ig || !ireq) m_cnt = 0;
      else if (e_dg && m_cnt < LIM) m_cnt++;
      if (m_lock == 0 && own != 0 && !grnt) begin m_lock = 1; m_aown = own; end
      else if (m_lock == 1 && grnt) m_lock = 0;
    end
    @(negedge clk);
  endtask

  task automatic clear();
    {rst, ireq, dreq, dwr, pm, grnt, cmplt, vld, err} = '0;
    {iaddr, daddr, dwd, rdata} = '0;
  endtask

  task automatic do_reset();
    clear();
    rst = 1;
    step();
    rst = 0;
  endtask

  typedef struct {
    logic ireq; logic [31:0] iaddr; logic dreq, dwr; logic [31:0] daddr, dwd;
    logic pm, grnt, cmplt, vld, err; logic [31:0] rdata;
    logic e_req; logic [31:0] e_addr; logic e_ig, e_dg, e_ivld, e_icmp, e_dcmp, e_idle;
  } vec_t;

  vec_t vt[9];
  string pat = "DDDDIDDDDI";

  initial begin
    vt[0] = '{1, 32'h100, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 32'h100, 1, 0, 0, 0, 0, 1};
    vt[1] = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 32'hA5A5, 0, 0, 0, 0, 1, 1, 0, 0};
    vt[2] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1};
    vt[3] = '{0, 0, 1, 1, 32'h2000, 32'h12345678, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1};
    vt[4] = '{0, 0, 1, 1, 32'h2000, 32'h12345678, 0, 1, 0, 0, 0, 0, 1, 32'h2000, 0, 1, 0, 0, 0, 1};
    vt[5] = '{1, 32'h140, 1, 0, 32'h3000, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0};
    vt[6] = '{1, 32'h140, 1, 0, 32'h3000, 0, 0, 0, 0, 0, 0, 0, 1, 32'h3000, 0, 0, 0, 0, 0, 1};
    vt[7] = '{1, 32'h140, 1, 0, 32'h3000, 0, 1, 0, 0, 0, 0, 0, 1, 32'h3000, 0, 0, 0, 0, 0, 0};
    vt[8] = '{1, 32'h140, 1, 0, 32'h3000, 0, 1, 1, 0, 0, 0, 0, 1, 32'h3000, 0, 1, 0, 0, 0, 0};
    @(negedge clk);
    do_reset();
    chk("rst_req", {31'd0, cpu_req}, 0);
    chk("rst_idle", {31'd0, idle}, 1);
    chk("rst_wdata", cpu_wdata, 0);
    for (int i = 0; i < 9; i++) begin
      {ireq, iaddr, dreq, dwr, daddr, dwd, pm, grnt, cmplt, vld, err, rdata} =
        {vt[i].ireq, vt[i].iaddr, vt[i].dreq, vt[i].dwr, vt[i].daddr, vt[i].dwd,
         vt[i].pm, vt[i].grnt, vt[i].cmplt, vt[i].vld, vt[i].err, vt[i].rdata};
      step();
      chk($sformatf("vec%0d_req", i), {31'd0, s_req}, {31'd0, vt[i].e_req});
      chk($sformatf("vec%0d_addr", i), s_addr, vt[i].e_addr);
      chk($sformatf("vec%0d_resp", i), {26'd0, s_ig, s_dg, s_ivld, s_icmp, s_dcmp, s_idle},
          {26'd0, vt[i].e_ig, vt[i].e_dg, vt[i].e_ivld, vt[i].e_icmp, vt[i].e_dcmp, vt[i].e_idle});
    end
    chk("vec_wdata", s_wdata, 32'h12345678);
    chk("vec_rdata", bus_rdata, 32'h0);
    // starvation: both requesting, granted every cycle
    do_reset();
    {ireq, dreq, grnt, iaddr, daddr} = {3'b111, 32'h400, 32'h800};
    begin
      int ng = 0;
      for (int i = 0; i < 10; i++) begin
        step();
        ng += s_ing;
        chk($sformatf("starve%0d", i), {30'd0, s_ig, s_dg}, pat[i] == "I" ? 32'd2 : 32'd1);
      end
      chk("starve_not_granted", ng, 8);
    end
    // dbus write held in LOCK for three cycles while ibus rises
    do_reset();
    {dreq, dwr, daddr, dwd} = {2'b11, 32'h2000, 32'hDEADBEEF};
    for (int i = 0; i < 4; i++) begin
      ireq = i >= 1;
      iaddr = 32'h500;
      grnt = i == 3;
      step();
      chk($sformatf("lock_addr%0d", i), s_addr, 32'h2000);
      chk($sformatf("lock_dg%0d", i), {31'd0, s_dg}, {31'd0, i == 3});
    end
    {dreq, grnt} = '0;
    step();
    chk("lock_wdata", s_wdata, 32'hDEADBEEF);
    // back-to-back: dbus granted while ibus completes with error
    do_reset();
    {ireq, iaddr, grnt} = {1'b1, 32'h600, 1'b1};
    step();
    chk("b2b_ig", {31'd0, s_ig}, 1);
    {ireq, dreq, daddr, dwr, cmplt, err} = {1'b0, 1'b1, 32'h700, 1'b0, 1'b1, 1'b1};
    step();
    chk("b2b_ierr_dg", {30'd0, s_ierr, s_dg}, 3);
    {dreq, grnt, err} = '0;
    step();
    chk("b2b_dcmp", {30'd0, s_icmp, s_dcmp}, 1);
    // reset while locked
    do_reset();
    {dreq, daddr} = {1'b1, 32'h900};
    step();
    chk("rl_lock_req", {31'd0, s_req}, 1);
    rst = 1;
    step();
    clear();
    step();
    chk("rl_after", {30'd0, s_req, s_idle}, 1);
    // randomized traffic obeying the hold-until-grant protocol
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if (!(ireq && !s_ig)) begin
        ireq = $urandom_range(0, 1);
        iaddr = $urandom;
        isize = 2'($urandom);
        iprot = 4'($urandom);
      end
      if (!(dreq && !s_dg)) begin
        dreq = $urandom_range(0, 1);
        daddr = $urandom;
        dwr = $urandom_range(0, 1);
        dwd = $urandom;
        dsize = 2'($urandom);
        dprot = 4'($urandom);
      end
      rst = $urandom_range(0, 99) == 0;
      pm = $urandom_range(0, 3) == 0;
      grnt = $urandom_range(0, 1);
      cmplt = $urandom_range(0, 1);
      vld = $urandom_range(0, 1);
      err = $urandom_range(0, 1);
      rdata = $urandom;
      step();
      if (rst) {s_ig, s_dg} = 2'b11;
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
